// File: rtl/archie_mem_pkg.sv
// archie_mem_pkg: shared types and constants for the SDRAM port arbiter.
// Holds the loader state enum, the default ROM bank and byte-lane selects.
package archie_mem_pkg;

    typedef enum logic [2:0] {
        ST_PASS,
        ST_DRAIN,
        ST_ERASE,
        ST_DL_IDLE,
        ST_DL_WR,
        ST_DL_END
    } arb_state_e;

    localparam logic [1:0] ROM_BASE_DEFAULT = 2'b01;

    localparam logic [3:0] SEL_LO  = 4'b0011;
    localparam logic [3:0] SEL_HI  = 4'b1100;
    localparam logic [3:0] SEL_ALL = 4'b1111;

endpackage

// File: rtl/ram_loader_arb_if.sv
// ram_loader_arb_if: classic wishbone bus, word addressed, AW address bits.
// master drives stb/cyc/we/sel/adr/dat, slave returns ack.
interface ram_loader_arb_if #(
    parameter int AW = 24
) ();

    logic          stb;
    logic          cyc;
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic          ack;

    modport master (
        output stb, cyc, we, sel, adr, dat,
        input  ack
    );

    modport slave (
        input  stb, cyc, we, sel, adr, dat,
        output ack
    );

endinterface

// File: rtl/wb_req_hold.sv
// wb_req_hold: registered wishbone request; load_i captures a new request,
// ack_i releases it. Ports: clk/rst, load + fields in, ack in, bus out.
module wb_req_hold (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        ack_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [23:0] adr_i,
    input  logic [31:0] dat_i,
    output logic        stb_o,
    output logic        cyc_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [23:0] adr_o,
    output logic [31:0] dat_o
);

    logic        req_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [23:0] adr_q;
    logic [31:0] dat_q;

    // load wins over ack so back-to-back requests keep stb high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
        end else if (load_i) begin
            req_q <= 1'b1;
            we_q  <= we_i;
            sel_q <= sel_i;
            adr_q <= adr_i;
            dat_q <= dat_i;
        end else if (ack_i) begin
            req_q <= 1'b0;
        end
    end

    assign stb_o = req_q;
    assign cyc_o = req_q;
    assign we_o  = we_q;
    assign sel_o = sel_q;
    assign adr_o = adr_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/ram_loader_arb.sv
// ram_loader_arb: shares the SDRAM wishbone port between the core and the
// ROM download path. Ports: clk_sys/reset, dl_* download, core/ram buses.
module ram_loader_arb
    import archie_mem_pkg::*;
#(
    parameter int         ERASE_AW = 20,
    parameter logic [1:0] ROM_BASE = ROM_BASE_DEFAULT
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             dl_active_i,
    input  logic             dl_wr_i,
    input  logic [21:0]      dl_addr_i,
    input  logic [15:0]      dl_data_i,
    output logic             dl_wait_o,
    output logic             dl_overrun_o,
    output logic             busy_o,
    ram_loader_arb_if.slave  core,
    ram_loader_arb_if.master ram
);

    arb_state_e          state_q, state_d;
    logic [ERASE_AW-1:0] cnt_q, cnt_d, cnt_nxt;
    logic                wait_q, wait_d;
    logic                ovr_q, ovr_d;
    logic                busy_q;
    logic                core_owns;

    logic        ld;
    logic [3:0]  ld_sel;
    logic [23:0] ld_adr;
    logic [31:0] ld_dat;
    logic        h_ack;
    logic        h_stb, h_cyc, h_we;
    logic [3:0]  h_sel;
    logic [23:0] h_adr;
    logic [31:0] h_dat;

    // halfword lanes come from dl_addr[1]; bit 0 carries no information
    logic unused_dl_bit;
    assign unused_dl_bit = dl_addr_i[0];

    function automatic logic [23:0] erase_adr(input logic [ERASE_AW-1:0] c);
        logic [23:0] a;
        a = '0;
        a[ERASE_AW-1:0] = c;
        return a;
    endfunction

    assign cnt_nxt   = cnt_q + ERASE_AW'(1);
    assign core_owns = (state_q == ST_PASS) || (state_q == ST_DRAIN);
    assign h_ack     = ram.ack & ~core_owns;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        wait_d  = 1'b0;
        ld      = 1'b0;
        ld_sel  = SEL_ALL;
        ld_adr  = '0;
        ld_dat  = '0;
        unique case (state_q)
            ST_PASS: begin
                if (dl_active_i) begin
                    wait_d = 1'b1;
                    if (core.cyc) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ERASE;
                        cnt_d   = '0;
                        ld      = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                wait_d = 1'b1;
                ovr_d  = ovr_q | dl_wr_i;
                if (!core.cyc) begin
                    state_d = ST_ERASE;
                    cnt_d   = '0;
                    ld      = 1'b1;
                end
            end
            ST_ERASE: begin
                wait_d = 1'b1;
                ovr_d  = ovr_q | dl_wr_i;
                if (ram.ack) begin
                    cnt_d = cnt_nxt;
                    if (!dl_active_i) begin
                        state_d = ST_PASS;
                    end else if (&cnt_q) begin
                        state_d = ST_DL_IDLE;
                    end else begin
                        ld     = 1'b1;
                        ld_adr = erase_adr(cnt_nxt);
                    end
                end
            end
            ST_DL_IDLE: begin
                if (dl_wr_i) begin
                    wait_d  = 1'b1;
                    ld      = 1'b1;
                    ld_adr  = {ROM_BASE, 2'b00, dl_addr_i[21:2]};
                    ld_sel  = dl_addr_i[1] ? SEL_HI : SEL_LO;
                    ld_dat  = {dl_data_i, dl_data_i};
                    state_d = ST_DL_WR;
                end else if (!dl_active_i) begin
                    state_d = ST_PASS;
                end
            end
            ST_DL_WR: begin
                wait_d = 1'b1;
                ovr_d  = ovr_q | dl_wr_i;
                if (ram.ack) begin
                    state_d = dl_active_i ? ST_DL_IDLE : ST_DL_END;
                end
            end
            ST_DL_END: state_d = ST_PASS;
            default:   state_d = ST_PASS;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_PASS;
            cnt_q   <= '0;
            wait_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != ST_PASS);
        end
    end

    wb_req_hold u_hold (
        .clk_i  (clk_sys),
        .rst_i  (reset),
        .load_i (ld),
        .ack_i  (h_ack),
        .we_i   (1'b1),
        .sel_i  (ld_sel),
        .adr_i  (ld_adr),
        .dat_i  (ld_dat),
        .stb_o  (h_stb),
        .cyc_o  (h_cyc),
        .we_o   (h_we),
        .sel_o  (h_sel),
        .adr_o  (h_adr),
        .dat_o  (h_dat)
    );

    // in DRAIN a new strobe must not start once the core drops cyc
    always_comb begin
        core.ack = 1'b0;
        ram.stb  = h_stb;
        ram.cyc  = h_cyc;
        ram.we   = h_we;
        ram.sel  = h_sel;
        ram.adr  = h_adr;
        ram.dat  = h_dat;
        if (core_owns) begin
            ram.stb  = core.stb & (core.cyc | (state_q == ST_PASS));
            ram.cyc  = core.cyc;
            ram.we   = core.we;
            ram.sel  = core.sel;
            ram.adr  = {2'b00, core.adr};
            ram.dat  = core.dat;
            core.ack = ram.ack;
        end
    end

    assign dl_wait_o    = wait_q;
    assign dl_overrun_o = ovr_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_ram_loader_arb.sv
// tb_ram_loader_arb: directed bench with a write-list model and a
// per-cycle compare process for the SDRAM port arbiter.
module tb_ram_loader_arb;

    typedef struct {
        logic [23:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wr_t;

    logic        clk_sys;
    logic        reset;
    logic        dl_active, dl_wr;
    logic [21:0] dl_addr;
    logic [15:0] dl_data;
    logic        dl_wait, dl_overrun, busy;

    int checks = 0;
    int errors = 0;

    wr_t exp_q[$];

    int ack_lat = 0;
    bit ack_en  = 1'b1;
    int wcnt    = 0;
    int acks;

    ram_loader_arb_if #(.AW(22)) cb ();
    ram_loader_arb_if #(.AW(24)) rb ();

    ram_loader_arb #(
        .ERASE_AW (4),
        .ROM_BASE (2'b01)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .dl_active_i  (dl_active),
        .dl_wr_i      (dl_wr),
        .dl_addr_i    (dl_addr),
        .dl_data_i    (dl_data),
        .dl_wait_o    (dl_wait),
        .dl_overrun_o (dl_overrun),
        .busy_o       (busy),
        .core         (cb),
        .ram          (rb)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic wr_t dl_exp(input logic [21:0] a, input logic [15:0] d);
        wr_t w;
        w.adr = {2'b01, 2'b00, a[21:2]};
        w.sel = a[1] ? 4'b1100 : 4'b0011;
        w.dat = {d, d};
        return w;
    endfunction

    task automatic push_erase(input int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.adr = 24'(i);
            w.sel = 4'hF;
            w.dat = 32'h0;
            exp_q.push_back(w);
        end
    endtask

    task automatic cyc1();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk_sys);
    endtask

    task automatic wait_wr_acks(input int n, output int first,
                                output int last, output bit ok);
        int seen = 0;
        first = -1;
        last  = -1;
        ok    = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk_sys);
            if (rb.stb && rb.cyc && rb.we && rb.ack) begin
                if (seen == 0) first = t;
                seen++;
                last = t;
                if (seen == n) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic core_burst(input logic [21:0] base, input int n,
                              output int got);
        got    = 0;
        cb.cyc = 1'b1;
        cb.stb = 1'b1;
        cb.we  = 1'b0;
        cb.sel = 4'hF;
        for (int b = 0; b < n; b++) begin
            int t = 0;
            cb.adr = base + 22'(b);
            while (t < 40) begin
                @(negedge clk_sys);
                if (cb.ack) break;
                t++;
                @(posedge clk_sys);
                #1;
            end
            if (t < 40) got++;
            @(posedge clk_sys);
            #1;
        end
        cb.cyc = 1'b0;
        cb.stb = 1'b0;
    endtask

    // bus slave: ack after ack_lat waiting cycles, back-to-back when 0
    initial begin
        rb.ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #2;
            if (!ack_en || !(rb.stb && rb.cyc)) begin
                rb.ack = 1'b0;
                wcnt   = 0;
            end else if (wcnt >= ack_lat) begin
                rb.ack = 1'b1;
                wcnt   = 0;
            end else begin
                rb.ack = 1'b0;
                wcnt++;
            end
        end
    end

    logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic        p_rst = 1'b1, p_ovr = 1'b0;
    logic [3:0]  p_sel;
    logic [23:0] p_adr;
    logic [31:0] p_dat;

    // loader writes are the only RAM writes: each acked one must match the list
    initial begin
        wr_t e;
        forever begin
            @(negedge clk_sys);
            if (!reset) begin
                if (rb.stb && rb.cyc && rb.we && rb.ack) begin
                    chk("wr_expected", 64'(exp_q.size() > 0), 1);
                    chk("iso_ack", cb.ack, 0);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("wr_fields", {rb.adr, rb.sel, rb.dat},
                            {e.adr, e.sel, e.dat});
                    end
                end
                if (p_stb && !p_ack && p_we && !p_rst) begin
                    chk("hold_stb", rb.stb, 1);
                    chk("hold_fields", {rb.adr, rb.sel, rb.dat, rb.we},
                        {p_adr, p_sel, p_dat, 1'b1});
                end
                if (rb.stb && rb.cyc && !rb.we) begin
                    chk("pass_adr", rb.adr, {2'b00, cb.adr});
                    chk("pass_ack", cb.ack, rb.ack);
                end
                if (p_ovr && !p_rst) chk("ovr_sticky", dl_overrun, 1);
            end
            p_stb = rb.stb & rb.cyc;
            p_ack = rb.ack;
            p_we  = rb.we;
            p_adr = rb.adr;
            p_sel = rb.sel;
            p_dat = rb.dat;
            p_rst = reset;
            p_ovr = dl_overrun;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] va [4];
        logic [15:0] vd [4];
        int f, l, t;
        bit ok;
        va = '{22'h000006, 22'h000000, 22'h3FFFFC, 22'h000003};
        vd = '{16'hBEEF, 16'h1234, 16'hC0DE, 16'hA55A};

        reset     = 1'b1;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        cb.stb    = 1'b0;
        cb.cyc    = 1'b0;
        cb.we     = 1'b0;
        cb.sel    = '0;
        cb.adr    = '0;
        cb.dat    = '0;
        repeat (3) cyc1();
        reset = 1'b0;
        nedge();
        chk("rst_busy", busy, 0);
        chk("rst_wait", dl_wait, 0);
        chk("rst_ovr", dl_overrun, 0);
        chk("rst_stb", rb.stb, 0);
        chk("rst_cack", cb.ack, 0);

        // idle passthrough
        cyc1();
        ack_lat = 3;
        cb.cyc  = 1'b1;
        cb.stb  = 1'b1;
        cb.sel  = 4'hF;
        cb.adr  = 22'h000100;
        nedge();
        chk("pt_adr", rb.adr, 24'h000100);
        chk("pt_stb", rb.stb, 1);
        chk("pt_busy", busy, 0);
        t = 0;
        while (t < 20 && !cb.ack) begin
            cyc1();
            nedge();
            t++;
        end
        chk("pt_lat", t, 3);
        cyc1();
        cb.cyc = 1'b0;
        cb.stb = 1'b0;

        // drain then erase
        cyc1();
        ack_lat = 1;
        push_erase(16);
        fork
            core_burst(22'h000040, 4, acks);
            begin
                cyc1();
                dl_active = 1'b1;
                nedge();
                chk("dr_wait0", dl_wait, 0);
                nedge();
                chk("dr_wait1", dl_wait, 1);
                chk("dr_busy", busy, 1);
            end
        join
        chk("dr_acks", acks, 4);
        ack_lat = 0;
        wait_wr_acks(16, f, l, ok);
        chk("er_done", ok, 1);
        chk("er_b2b", l - f, 15);
        nedge();
        chk("er_wait_p1", dl_wait, 1);
        nedge();
        chk("er_wait_p2", dl_wait, 0);
        chk("er_busy", busy, 1);
        chk("er_q", exp_q.size(), 0);

        // download lanes
        ack_lat = 2;
        for (int i = 0; i < 4; i++) begin
            cyc1();
            dl_wr   = 1'b1;
            dl_addr = va[i];
            dl_data = vd[i];
            exp_q.push_back(dl_exp(va[i], vd[i]));
            nedge();
            chk("dl_wait_pre", dl_wait, 0);
            cyc1();
            dl_wr = 1'b0;
            nedge();
            chk("dl_wait_wr", dl_wait, 1);
            if (i == 0) begin
                chk("dl_adr", rb.adr, 24'h400001);
                chk("dl_sel", rb.sel, 4'b1100);
                chk("dl_dat", rb.dat, 32'hBEEFBEEF);
                chk("dl_we", {rb.we, rb.stb}, 2'b11);
            end
            wait_wr_acks(1, f, l, ok);
            chk("dl_ack", ok, 1);
            nedge();
            chk("dl_wait_a1", dl_wait, 1);
            nedge();
            chk("dl_wait_a2", dl_wait, 0);
        end
        cyc1();
        dl_active = 1'b0;
        nedge();
        nedge();
        chk("dl_end_busy", busy, 0);

        // overrun during erase
        cyc1();
        ack_lat   = 2;
        push_erase(16);
        dl_active = 1'b1;
        repeat (6) cyc1();
        dl_wr   = 1'b1;
        dl_addr = 22'h000010;
        dl_data = 16'hDEAD;
        nedge();
        chk("ovr_pre", dl_overrun, 0);
        cyc1();
        dl_wr = 1'b0;
        nedge();
        chk("ovr_set", dl_overrun, 1);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            nedge();
            if (!dl_wait) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ovr_erase_end", ok, 1);
        repeat (4) nedge();
        chk("ovr_q", exp_q.size(), 0);
        chk("ovr_keep", dl_overrun, 1);
        cyc1();
        dl_active = 1'b0;
        nedge();
        nedge();
        chk("ovr_busy", busy, 0);

        // early end of erase at word 7
        cyc1();
        ack_lat   = 1;
        push_erase(8);
        dl_active = 1'b1;
        wait_wr_acks(7, f, l, ok);
        chk("ee_seven", ok, 1);
        cyc1();
        dl_active = 1'b0;
        wait_wr_acks(1, f, l, ok);
        chk("ee_eighth", ok, 1);
        cyc1();
        ack_lat = 3;
        cb.cyc  = 1'b1;
        cb.stb  = 1'b1;
        cb.adr  = 22'h000200;
        nedge();
        chk("ee_busy", busy, 0);
        chk("ee_stb", rb.stb, 1);
        chk("ee_adr", rb.adr, 24'h000200);
        chk("ee_we", rb.we, 0);
        chk("ee_q", exp_q.size(), 0);
        t = 0;
        while (t < 20 && !cb.ack) begin
            cyc1();
            nedge();
            t++;
        end
        chk("ee_cack", cb.ack, 1);
        cyc1();
        cb.cyc = 1'b0;
        cb.stb = 1'b0;

        // reset in the middle of a download write
        cyc1();
        ack_lat   = 0;
        push_erase(16);
        dl_active = 1'b1;
        wait_wr_acks(16, f, l, ok);
        chk("rw_erase", ok, 1);
        cyc1();
        ack_en  = 1'b0;
        dl_wr   = 1'b1;
        dl_addr = 22'h000008;
        dl_data = 16'h5A5A;
        cyc1();
        dl_wr = 1'b0;
        nedge();
        chk("rw_stb", rb.stb, 1);
        chk("rw_adr", rb.adr, 24'h400002);
        chk("rw_busy", busy, 1);
        cyc1();
        reset = 1'b1;
        nedge();
        cyc1();
        reset     = 1'b0;
        dl_active = 1'b0;
        nedge();
        chk("rw_stb0", rb.stb, 0);
        chk("rw_wait0", dl_wait, 0);
        chk("rw_busy0", busy, 0);
        chk("rw_ovr0", dl_overrun, 0);
        cyc1();
        ack_en  = 1'b1;
        ack_lat = 1;
        cb.cyc  = 1'b1;
        cb.stb  = 1'b1;
        cb.adr  = 22'h000300;
        nedge();
        chk("rw_fwd_stb", rb.stb, 1);
        chk("rw_fwd_adr", rb.adr, 24'h000300);
        t = 0;
        while (t < 20 && !cb.ack) begin
            cyc1();
            nedge();
            t++;
        end
        chk("rw_cack", cb.ack, 1);
        cyc1();
        cb.cyc = 1'b0;
        cb.stb = 1'b0;
        repeat (3) cyc1();
        chk("final_q", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
